// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control / multiply unit:
// ALUOp and funct encodings, ALU control codes and the MDU state type.
package alu_ctrl_pkg;

  // ALUOp values from main control
  localparam logic [5:0] OP_LW    = 6'b000000;  // lw/sw/addi
  localparam logic [5:0] OP_BEQ   = 6'b000001;
  localparam logic [5:0] OP_RTYPE = 6'b000010;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  // R-type funct values
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_BREAK = 6'b001101;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;

  // ALU control codes
  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_XOR   = 4'b0011;
  localparam logic [3:0] ALU_ADDU  = 4'b0100;
  localparam logic [3:0] ALU_SUBU  = 4'b0101;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_MULT  = 4'b1000;
  localparam logic [3:0] ALU_MULTU = 4'b1001;
  localparam logic [3:0] ALU_LUI   = 4'b1010;
  localparam logic [3:0] ALU_SLTU  = 4'b1011;
  localparam logic [3:0] ALU_BREAK = 4'b1111;

  typedef enum logic [1:0] {IDLE, RUN, FIX} mdu_state_t;

endpackage

// File: rtl/mdu_seq_mult.sv
// Sequential shift-add multiplier with HI/LO result registers.
// Signed multiplies run on magnitudes and negate the product in FIX.
// Build option: MDU_RADIX4_EN retires 2 multiplier bits per RUN cycle
// instead of 1; the results are identical, only the latency changes.
module mdu_seq_mult
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

`ifdef MDU_RADIX4_EN
  localparam int STEP_BITS = 2;
`else
  localparam int STEP_BITS = 1;
`endif
  localparam int STEPS = WIDTH / STEP_BITS;
  localparam int CNT_W = $clog2(WIDTH);
  localparam int PW    = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  mdu_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic             sign_q, sign_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0] rs_mag, rt_mag;
  logic [PW-1:0]    addend, product;

  // State and datapath registers, all cleared by the synchronous reset
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every flop updates from pre-edge values.
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      sign_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      sign_q   <= sign_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Next-state logic: a new request is only taken in IDLE
  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == LAST_STEP) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand capture, per-step partial-product add, sign fix
  always_comb begin
    // Unsigned WIDTH-bit magnitude; the most-negative value wraps to itself.
    rs_mag = (is_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
    rt_mag = (is_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;
`ifdef MDU_RADIX4_EN
    case (mplier_q[1:0])
      2'd1:    addend = mcand_q;
      2'd2:    addend = mcand_q << 1;
      2'd3:    addend = (mcand_q << 1) + mcand_q;
      default: addend = '0;
    endcase
`else
    addend = mplier_q[0] ? mcand_q : '0;
`endif
    product  = sign_q ? -acc_q : acc_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    sign_d   = sign_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      IDLE: if (start) begin
        mcand_d  = {{WIDTH{1'b0}}, rs_mag};
        mplier_d = rt_mag;
        acc_d    = '0;
        cnt_d    = '0;
        sign_d   = is_signed & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
      end
      RUN: begin
        acc_d    = acc_q + addend;
        mcand_d  = mcand_q << STEP_BITS;
        mplier_d = mplier_q >> STEP_BITS;
        cnt_d    = cnt_q + 1'b1;
      end
      FIX: begin
        hi_d = product[PW-1:WIDTH];
        lo_d = product[WIDTH-1:0];
      end
      default: ;
    endcase
  end

  // Handshake outputs decoded from the state
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == FIX);
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/alu_control_mdu.sv
// ALU control decode (ALUOp + funct -> control code), sticky break
// request, and the sequential multiply unit for mult/multu.
// Build option: MDU_RADIX4_EN selects the 2-bit-per-cycle multiplier.
module alu_control_mdu
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [5:0]        op,
  input  logic [5:0]        funct,
  input  logic [WIDTH-1:0]  rs_val,
  input  logic [WIDTH-1:0]  rt_val,
  output logic [CTRL_W-1:0] control,
  output logic              mdu_busy,
  output logic              mdu_done,
  output logic [WIDTH-1:0]  hi,
  output logic [WIDTH-1:0]  lo,
  output logic              break_req
);

  logic [3:0] code;
  logic       is_rtype, mul_start, break_d, break_q;

  // Control decode; unlisted op/funct combinations fall to ALU_AND
  always_comb begin
    code = ALU_AND;
    case (op)
      OP_LW:    code = ALU_ADD;
      OP_BEQ:   code = ALU_SUB;
      OP_ORI:   code = ALU_OR;
      OP_ANDI:  code = ALU_AND;
      OP_ADDIU: code = ALU_ADDU;
      OP_SLTI:  code = ALU_SLT;
      OP_SLTIU: code = ALU_SLTU;
      OP_LUI:   code = ALU_LUI;
      OP_RTYPE: begin
        case (funct)
          FN_AND:   code = ALU_AND;
          FN_OR:    code = ALU_OR;
          FN_ADD:   code = ALU_ADD;
          FN_JR:    code = ALU_ADD;
          FN_XOR:   code = ALU_XOR;
          FN_ADDU:  code = ALU_ADDU;
          FN_SUBU:  code = ALU_SUBU;
          FN_SUB:   code = ALU_SUB;
          FN_SLT:   code = ALU_SLT;
          FN_MULT:  code = ALU_MULT;
          FN_MULTU: code = ALU_MULTU;
          FN_SLTU:  code = ALU_SLTU;
          FN_BREAK: code = ALU_BREAK;
          default:  code = ALU_AND;
        endcase
      end
      default: code = ALU_AND;
    endcase
  end

  // Multiply request and sticky break detection
  always_comb begin
    is_rtype  = in_valid && (op == OP_RTYPE);
    mul_start = is_rtype && ((funct == FN_MULT) || (funct == FN_MULTU));
    break_d   = break_q | (is_rtype && (funct == FN_BREAK));
  end

  // Break flag holds until reset
  always_ff @(posedge clock) begin
    if (reset) break_q <= 1'b0;
    else       break_q <= break_d;
  end

  assign control   = CTRL_W'(code);
  assign break_req = break_q;

  mdu_seq_mult #(.WIDTH(WIDTH)) u_mdu (
    .clock     (clock),
    .reset     (reset),
    .start     (mul_start),
    .is_signed (funct == FN_MULT),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .busy      (mdu_busy),
    .done      (mdu_done),
    .hi        (hi),
    .lo        (lo)
  );

endmodule

// File: tb/tb_alu_control_mdu.sv
// Self-checking bench for alu_control_mdu: table-driven decode model,
// arithmetic product model, cycle-exact busy/done/hi/lo checks.
module tb_alu_control_mdu;

  localparam int WIDTH = 32;
`ifdef MDU_RADIX4_EN
  localparam int STEPS = WIDTH / 2;
`else
  localparam int STEPS = WIDTH;
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [5:0]        op, funct;
  logic [WIDTH-1:0]  rs_val, rt_val;
  logic [3:0]        control;
  logic              mdu_busy, mdu_done, break_req;
  logic [WIDTH-1:0]  hi, lo;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference state
  logic [31:0] m_hi    = '0;
  logic [31:0] m_lo    = '0;
  bit          m_break = 1'b0;

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    bit         any_funct;
    logic [3:0] code;
  } dec_t;

  dec_t tab [21] = '{
    '{6'b000000, 6'b000000, 1'b1, 4'b0010},
    '{6'b000001, 6'b000000, 1'b1, 4'b0110},
    '{6'b001101, 6'b000000, 1'b1, 4'b0001},
    '{6'b001100, 6'b000000, 1'b1, 4'b0000},
    '{6'b001001, 6'b000000, 1'b1, 4'b0100},
    '{6'b001010, 6'b000000, 1'b1, 4'b0111},
    '{6'b001011, 6'b000000, 1'b1, 4'b1011},
    '{6'b001111, 6'b000000, 1'b1, 4'b1010},
    '{6'b000010, 6'b100100, 1'b0, 4'b0000},
    '{6'b000010, 6'b100101, 1'b0, 4'b0001},
    '{6'b000010, 6'b100000, 1'b0, 4'b0010},
    '{6'b000010, 6'b001000, 1'b0, 4'b0010},
    '{6'b000010, 6'b100110, 1'b0, 4'b0011},
    '{6'b000010, 6'b100001, 1'b0, 4'b0100},
    '{6'b000010, 6'b100011, 1'b0, 4'b0101},
    '{6'b000010, 6'b100010, 1'b0, 4'b0110},
    '{6'b000010, 6'b101010, 1'b0, 4'b0111},
    '{6'b000010, 6'b011000, 1'b0, 4'b1000},
    '{6'b000010, 6'b011001, 1'b0, 4'b1001},
    '{6'b000010, 6'b101011, 1'b0, 4'b1011},
    '{6'b000010, 6'b001101, 1'b0, 4'b1111}
  };

  alu_control_mdu #(.WIDTH(WIDTH), .CTRL_W(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .op        (op),
    .funct     (funct),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .control   (control),
    .mdu_busy  (mdu_busy),
    .mdu_done  (mdu_done),
    .hi        (hi),
    .lo        (lo),
    .break_req (break_req)
  );

  always #5 clock = ~clock;

  // First matching table row wins; anything unlisted decodes to 0000
  function automatic logic [3:0] ref_control(input logic [5:0] o, input logic [5:0] f);
    foreach (tab[i])
      if (tab[i].op == o && (tab[i].any_funct || tab[i].funct == f)) return tab[i].code;
    return 4'b0000;
  endfunction

  function automatic logic [63:0] ref_product(input bit s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    op       = 6'b111111;
    funct    = 6'b000000;
    rs_val   = $urandom;
    rt_val   = $urandom;
  endtask

  // One multiply from request (cycle 0) through result visibility.
  // inject_at: cycle to fire an extra mult that must be ignored (0 = none).
  // reset_at: cycle to pulse reset, aborting the multiply (0 = none).
  task automatic run_mul(input bit s, input logic [31:0] a, input logic [31:0] b,
                         input int inject_at, input int reset_at, input string tag);
    logic [63:0] p;
    bit          aborted;
    p        = ref_product(s, a, b);
    aborted  = 1'b0;
    in_valid = 1'b1;
    op       = 6'b000010;
    funct    = s ? 6'b011000 : 6'b011001;
    rs_val   = a;
    rt_val   = b;
    #1;
    check({tag, "_ctl"}, 64'(control), 64'(s ? 4'b1000 : 4'b1001));
    check({tag, "_busy0"}, 64'(mdu_busy), 64'(1'b0));
    step();
    idle_inputs();
    for (int cyc = 1; cyc <= STEPS + 2; cyc++) begin
      check({tag, "_busy"}, 64'(mdu_busy), 64'(!aborted && cyc <= STEPS));
      check({tag, "_done"}, 64'(mdu_done), 64'(!aborted && cyc == STEPS + 1));
      if (cyc == STEPS + 2 && !aborted) begin
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      if (cyc >= STEPS + 1) begin
        check({tag, "_hi"}, 64'(hi), 64'(m_hi));
        check({tag, "_lo"}, 64'(lo), 64'(m_lo));
        check({tag, "_brk"}, 64'(break_req), 64'(m_break));
      end
      if (cyc == 3) begin
        // Ordinary op while busy still decodes
        in_valid = 1'b1;
        op       = 6'b000010;
        funct    = 6'b100000;
        #1;
        check({tag, "_ctl_busy"}, 64'(control), 64'(4'b0010));
      end
      if (cyc == inject_at) begin
        in_valid = 1'b1;
        op       = 6'b000010;
        funct    = 6'b011000;
        rs_val   = $urandom;
        rt_val   = $urandom;
      end
      if (cyc == reset_at) reset = 1'b1;
      step();
      idle_inputs();
      reset = 1'b0;
      if (cyc == reset_at) begin
        aborted = 1'b1;
        m_hi    = '0;
        m_lo    = '0;
        m_break = 1'b0;
      end
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    int          k;
    reset = 1'b1;
    idle_inputs();
    step();
    step();
    check("rst_busy", 64'(mdu_busy), 64'(1'b0));
    check("rst_done", 64'(mdu_done), 64'(1'b0));
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    check("rst_brk", 64'(break_req), 64'(1'b0));
    reset = 1'b0;
    step();

    // Decode sweep over every table row, then random op/funct pairs
    foreach (tab[i]) begin
      op    = tab[i].op;
      funct = tab[i].any_funct ? 6'($urandom) : tab[i].funct;
      #1;
      check("dec_tab", 64'(control), 64'(tab[i].code));
    end
    op = 6'b000010; funct = 6'b101011; #1;
    check("dec_sltu", 64'(control), 64'(4'b1011));
    op = 6'b111111; funct = 6'($urandom); #1;
    check("dec_op3f", 64'(control), 64'(4'b0000));
    for (int i = 0; i < 200; i++) begin
      k     = $urandom_range(0, 20);
      op    = ($urandom_range(0, 3) == 0) ? 6'($urandom) : tab[k].op;
      k     = $urandom_range(0, 20);
      funct = ($urandom_range(0, 3) == 0) ? 6'($urandom) : tab[k].funct;
      #1;
      check("dec_rand", 64'(control), 64'(ref_control(op, funct)));
    end
    step();
    check("dec_no_brk", 64'(break_req), 64'(1'b0));

    // Directed multiplies with known results
    run_mul(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, "multu_max");
    check("multu_max_hi_k", 64'(hi), 64'(32'hFFFFFFFE));
    check("multu_max_lo_k", 64'(lo), 64'(32'h00000001));
    run_mul(1'b1, 32'hFFFFFFFD, 32'h00000007, 0, 0, "mult_neg3x7");
    check("neg3x7_hi_k", 64'(hi), 64'(32'hFFFFFFFF));
    check("neg3x7_lo_k", 64'(lo), 64'(32'hFFFFFFEB));
    run_mul(1'b1, 32'h80000000, 32'h80000000, 0, 0, "mult_minneg");
    check("minneg_hi_k", 64'(hi), 64'(32'h40000000));
    check("minneg_lo_k", 64'(lo), 64'(32'h00000000));
    run_mul(1'b0, 32'h12345678, 32'h9ABCDEF0, 0, 0, "multu_r4");
    check("r4_hi_k", 64'(hi), 64'(32'h0B00EA4E));
    check("r4_lo_k", 64'(lo), 64'(32'h242D2080));
    run_mul(1'b1, 32'h00000000, 32'h80000001, 0, 0, "mult_zero");

    // A second mult at cycle 10 must be ignored
    run_mul(1'b1, 32'h00001234, 32'hFFFF0001, 10, 0, "mult_ignore");

    // Random multiplies against the arithmetic model
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i == 6) ra = 32'h80000000;
      run_mul(1'($urandom), ra, rb, 0, 0, "mul_rand");
    end

    // Reset in the middle of RUN: abort, outputs back to reset values
    run_mul(1'b0, 32'hDEADBEEF, 32'h12345679, 0, 15, "mul_abort");
    check("abort_hi_k", 64'(hi), 64'(0));
    check("abort_lo_k", 64'(lo), 64'(0));

    // Break request sets and holds until reset
    in_valid = 1'b1; op = 6'b000010; funct = 6'b001101; #1;
    check("brk_ctl", 64'(control), 64'(4'b1111));
    check("brk_pre", 64'(break_req), 64'(1'b0));
    step();
    idle_inputs();
    m_break = 1'b1;
    check("brk_set", 64'(break_req), 64'(m_break));
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; op = 6'b000001; funct = 6'($urandom);
      step();
      check("brk_hold", 64'(break_req), 64'(m_break));
    end
    idle_inputs();
    run_mul(1'b0, 32'h00000003, 32'h00000005, 0, 0, "mul_after_brk");
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_break = 1'b0;
    check("brk_clr", 64'(break_req), 64'(m_break));
    check("brk_clr_hi", 64'(hi), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
